// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDER_DBZ_EN (divide-by-zero shortcut and dbz flag).
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          valid,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] quo;
  logic [VW-1:0] prem;
  logic [VW-1:0] dvs;
  logic [VW:0]   sh;
  logic [VW+1:0] diff;
  logic [VW-1:0] p_nx;
  logic [DW-1:0] q_nx;
  logic          last;
`ifdef DIVIDER_DBZ_EN
  logic          zdiv;
`endif

  // prem stays below the divisor, so VW bits hold it between steps
  always_comb begin
    sh   = {prem, quo[DW-1]};
    diff = {1'b0, sh} - {2'b00, dvs};
    if (diff[VW+1]) begin
      p_nx = sh[VW-1:0];
      q_nx = {quo[DW-2:0], 1'b0};
    end else begin
      p_nx = diff[VW-1:0];
      q_nx = {quo[DW-2:0], 1'b1};
    end
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      quo       <= '0;
      prem      <= '0;
      dvs       <= '0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_EN
      dbz       <= 1'b0;
      zdiv      <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            quo   <= dividend;
            prem  <= '0;
            dvs   <= divisor;
            cnt   <= CW'(DW);
`ifdef DIVIDER_DBZ_EN
            zdiv  <= (divisor == '0);
            if (divisor == '0)
              cnt <= CW'(1);
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt  <= cnt - CW'(1);
          quo  <= q_nx;
          prem <= p_nx;
          if (last) begin
            state     <= DONE;
            ready     <= 1'b1;
            valid     <= 1'b1;
            quotient  <= q_nx;
            remainder <= p_nx;
`ifdef DIVIDER_DBZ_EN
            dbz <= zdiv;
            // zero divisor: quo still holds the untouched dividend
            if (zdiv) begin
              quotient  <= '1;
              remainder <= quo[VW-1:0];
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DIVIDER_DBZ_EN
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider against an arithmetic model.
// Honours DIVIDER_DBZ_EN for the zero-divisor latency and flag.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int nchk;
  int npass;
  logic [15:0] eq;
  logic [7:0]  er;

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain division; zero divisor yields all ones / low byte
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r,
                       output int lat, output logic z);
    if (b == 0) begin
      q = 16'hFFFF;
      r = a[7:0];
    end else begin
      q = a / 16'(b);
      r = 8'(a % 16'(b));
    end
    lat = 16;
    z   = 1'b0;
`ifdef DIVIDER_DBZ_EN
    if (b == 0) begin
      lat = 1;
      z   = 1'b1;
    end
`endif
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input int poke);
    int k;
    int elat;
    logic ez;
    model(a, b, eq, er, elat, ez);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    k = 0;
    do begin
      if (poke > 0 && k == poke) begin
        start    = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h11;
      end
      @(posedge clk);
      #1;
      k++;
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (k == 1 && elat > 1) chk("ready_low", 32'(ready), 32'd0);
    end while (!valid && k < 40);
    chk("latency", 32'(k), 32'(elat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("dbz", 32'(dbz), 32'(ez));
    chk("ready_done", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    chk("valid_pulse", 32'(valid), 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    logic [7:0] x;
    logic [7:0] y;
    nchk     = 0;
    npass    = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_quo", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd1000, 8'd7, 0);
    run_op(16'hFFFF, 8'hFF, 0);
    run_op(16'd5, 8'd9, 0);
    run_op(16'hFE01, 8'hFF, 0);
    run_op(16'h1234, 8'h00, 0);

    // stray start mid-run, then results must hold
    run_op(16'd1000, 8'd7, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_q", 32'(quotient), 32'd142);
      chk("hold_r", 32'(remainder), 32'd6);
    end

    // back-to-back with start held high
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 8'd3;
    @(posedge clk);
    #1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!valid && k < 40);
    chk("b2b_lat1", 32'(k), 32'd16);
    chk("b2b_q1", 32'(quotient), 32'd33);
    chk("b2b_r1", 32'(remainder), 32'd1);
    dividend = 16'd200;
    divisor  = 8'd9;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!valid && k < 40);
    start = 1'b0;
    chk("b2b_gap", 32'(k), 32'd17);
    chk("b2b_q2", 32'(quotient), 32'd22);
    chk("b2b_r2", 32'(remainder), 32'd2);
    @(posedge clk);
    #1;

    // reset in the middle of a run
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd777;
    divisor  = 8'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    chk("mid_rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid) seen++;
    end
    chk("no_stale_valid", 32'(seen), 32'd0);
    run_op(16'd50, 8'd5, 0);

    // random operands, including multiplier products
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) begin
        x = 8'($urandom);
        y = 8'($urandom_range(1, 255));
        run_op(16'(x) * 16'(y), y, 0);
        if (eq != 16'(x)) $display("model disagrees on product case");
      end else if (i % 7 == 0) begin
        run_op(16'($urandom), 8'h00, 0);
      end else begin
        run_op(16'($urandom), 8'($urandom), 0);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
